// File: rtl/dyn_patt_gen.sv
// dyn_patt_gen: serial pattern transmitter for the dynamic pattern detector.
//
// A start request latches a NUM_BITS-wide pattern. The pattern is either the
// PATTERN parameter or pattern_in, chosen by use_default. The pattern is sent
// MSB-first, one bit per clock, reps times. Optionally, gap idle cycles are
// inserted between repetitions. All outputs are registered.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        transmission request, sampled only in IDLE
//   use_default  1: send PATTERN, 0: send pattern_in (sampled with start)
//   pattern_in   runtime pattern (sampled with start)
//   reps         number of repetitions (sampled with start)
//   gap          idle cycles between repetitions (sampled with start)
//   fill         data value driven while valid=0
//   abort        cancels an in-progress transmission
//   data         serial bit, pattern MSB first
//   valid        data carries a pattern bit
//   busy         transmission in progress
//   done         one-cycle pulse at normal completion
//   sent_cnt     completed repetitions of the current or last job
//
// Optional build macro PATT_GEN_LFSR_EN: during GAP, the bits of an 8-bit
// Fibonacci LFSR are sent with valid=1. These are noise bits between
// repetitions.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, data=fill, valid=0
// SEND  | shifting out pattern bit idx_q with valid=1
// GAP   | gcnt_q remaining inter-repetition cycles
// FIN   | one-cycle completion, done=1
module dyn_patt_gen #(
  parameter int                  NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0] PATTERN  = 5'b10110,
  parameter int                  REP_W    = 4,
  parameter int                  GAP_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                use_default,
  input  logic [NUM_BITS-1:0] pattern_in,
  input  logic [REP_W-1:0]    reps,
  input  logic [GAP_W-1:0]    gap,
  input  logic                fill,
  input  logic                abort,
  output logic                data,
  output logic                valid,
  output logic                busy,
  output logic                done,
  output logic [REP_W-1:0]    sent_cnt
);

  localparam int IDX_W = $clog2(NUM_BITS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] pat_q, pat_d;
  logic [REP_W-1:0]    reps_q, reps_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gcnt_q, gcnt_d;
  logic [REP_W-1:0]    sent_d;
  logic                data_d, valid_d, busy_d, done_d;
  logic [REP_W-1:0]    sent_inc;
  logic                last_rep;

  assign sent_inc = sent_cnt + REP_W'(1);
  // sent_cnt counts finished repetitions, so the one now on its last bit is the
  // final one when the incremented count reaches the latched total.
  assign last_rep = (sent_inc == reps_q);

`ifdef PATT_GEN_LFSR_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, free-running from reset
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'h01;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`endif

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      reps_q   <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      gcnt_q   <= '0;
      sent_cnt <= '0;
      data     <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      reps_q   <= reps_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      gcnt_q   <= gcnt_d;
      sent_cnt <= sent_d;
      data     <= data_d;
      valid    <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // next state; abort outranks every busy-state transition
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = (reps == '0) ? S_FIN : S_SEND;
        S_SEND: begin
          if (idx_q == '0) begin
            if (last_rep)          state_d = S_FIN;
            else if (gap_q != '0)  state_d = S_GAP;
          end
        end
        S_GAP:  if (gcnt_q == GAP_W'(1)) state_d = S_SEND;
        S_FIN:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // datapath and next values of the registered outputs
  always_comb begin
    pat_d   = pat_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    sent_d  = sent_cnt;
    data_d  = fill;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (state_q == S_IDLE && start) begin
      pat_d  = use_default ? PATTERN : pattern_in;
      reps_d = reps;
      gap_d  = gap;
      sent_d = '0;
    end

    // The repetition is complete once its bit 0 has been shown, even if
    // abort arrives on that same edge.
    if (state_q == S_SEND && idx_q == '0) sent_d = sent_inc;

    if (state_q == S_GAP) gcnt_d = gcnt_q - GAP_W'(1);

    case (state_d)
      S_SEND: begin
        idx_d   = (state_q == S_SEND && idx_q != '0) ? idx_q - IDX_W'(1)
                                                     : IDX_W'(NUM_BITS-1);
        data_d  = pat_d[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_GAP: begin
        if (state_q == S_SEND) gcnt_d = gap_q;
        busy_d = 1'b1;
`ifdef PATT_GEN_LFSR_EN
        data_d  = lfsr_q[0];
        valid_d = 1'b1;
`endif
      end
      S_FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dyn_patt_gen.sv
module tb_dyn_patt_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic       use_default = 1'b0;
  logic [4:0] pattern_in = '0;
  logic [3:0] reps = '0;
  logic [2:0] gap = '0;
  logic       fill = 1'b0;
  logic       abort = 1'b0;
  logic       data, valid, busy, done;
  logic [3:0] sent_cnt;

  dyn_patt_gen dut (
    .clk(clk), .rst(rst), .start(start), .use_default(use_default),
    .pattern_in(pattern_in), .reps(reps), .gap(gap), .fill(fill),
    .abort(abort), .data(data), .valid(valid), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       data;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] sent;
    logic       skip_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  logic rst_q = 1'b1;
  logic fill_q = 1'b0;
  logic [3:0] last_sent = '0;

  always @(posedge clk) begin
    rst_q  <= rst;
    fill_q <= fill;
  end

  task automatic chk(string nm, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  function automatic exp_t mk(logic d, logic v, logic b, logic dn, int s, logic sk);
    exp_t e;
    e.data = d; e.valid = v; e.busy = b; e.done = dn; e.sent = 4'(s); e.skip_data = sk;
    return e;
  endfunction

  // monitor: one expected record per cycle while a job is queued
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sent", sent_cnt, 0);
      last_sent = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e.skip_data) chk("data", data, e.data);
      chk("valid", valid, e.valid);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("sent_cnt", sent_cnt, e.sent);
      last_sent = e.sent;
    end else begin
      chk("idle_data", data, fill_q);
      chk("idle_valid", valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sent", sent_cnt, last_sent);
    end
  end

  function automatic int job_len(int r, int g);
    return (r == 0) ? 1 : r * 5 + (r - 1) * g + 1;
  endfunction

  // Builds the expected cycle stream from the job description, then drives it.
  task automatic run_job(logic ud, logic [4:0] pin, int r, int g, logic f,
                         int abort_at, int reset_at, int mid_start);
    exp_t       l[$];
    logic [4:0] p;
    int         sa;
    int         n;
    p = ud ? 5'b10110 : pin;
    if (r == 0) begin
      l.push_back(mk(f, 0, 1, 1, 0, 0));
    end else begin
      for (int rr = 0; rr < r; rr++) begin
        for (int b = 4; b >= 0; b--) l.push_back(mk(p[b], 1, 1, 0, rr, 0));
        if (rr < r - 1)
          for (int gg = 0; gg < g; gg++)
`ifdef PATT_GEN_LFSR_EN
            l.push_back(mk(0, 1, 1, 0, rr + 1, 1));
`else
            l.push_back(mk(f, 0, 1, 0, rr + 1, 0));
`endif
      end
      l.push_back(mk(f, 0, 1, 1, r, 0));
    end
    n = l.size();
    if (abort_at >= 0) begin
      sa = 0;
      for (int rr = 0; rr < r; rr++)
        if (rr * (5 + g) + 4 <= abort_at) sa++;
      while (l.size() > abort_at + 1) void'(l.pop_back());
      l.push_back(mk(f, 0, 0, 0, sa, 0));
      n = abort_at + 1;
    end else begin
      l.push_back(mk(f, 0, 0, 0, r, 0));
    end

    @(negedge clk); #1;
    fill = f; use_default = ud; pattern_in = pin; reps = 4'(r); gap = 3'(g);
    start = 1'b1;
    foreach (l[i]) exp_q.push_back(l[i]);

    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      start = 1'b0; abort = 1'b0;
      pattern_in = 5'($urandom); reps = 4'($urandom); gap = 3'($urandom);
      use_default = 1'($urandom);
      if (k == mid_start) start = 1'b1;
      if (k == abort_at) abort = 1'b1;
      if (k == reset_at) begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        break;
      end
    end
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int w = 0; w < 400 && exp_q.size() != 0; w++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_mis++;
      $display("FAIL drain_timeout: %0d expected records left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, a, rs, ms, n;
    // reset held for two edges with start asserted
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk); #1;

    run_job(1, 5'b00000, 3, 0, 0, -1, -1, -1);
    run_job(0, 5'b11001, 2, 2, 1, -1, -1, -1);
    run_job(1, 5'b00000, 0, 3, 1, -1, -1, -1);
    run_job(1, 5'b00000, 4, 0, 0, 11, -1, 3);
    run_job(0, 5'b10011, 3, 1, 0, -1, 2, -1);
    run_job(0, 5'b10011, 3, 1, 1, -1, -1, -1);

    for (int j = 0; j < 40; j++) begin
      r  = $urandom_range(0, 15);
      g  = $urandom_range(0, 7);
      n  = job_len(r, g);
      a  = -1; rs = -1; ms = -1;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          a = $urandom_range(0, n - 1);
          // abort on a repetition's last bit is left out of random picks
          if (r > 0 && (a % (5 + g)) == 4 && (a / (5 + g)) < r) a = -1;
        end
        3: rs = $urandom_range(0, n - 1);
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) ms = $urandom_range(0, n - 1);
      run_job(1'($urandom), 5'($urandom), r, g, 1'($urandom), a, rs, ms);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dyn_patt_gen.md
Name: dyn_patt_gen

Overview:
Serial pattern transmitter; the driving end of the dynamic pattern detector's serial bit interface (data/valid). On a start request it latches a runtime-programmable NUM_BITS-wide pattern and emits it MSB-first, one bit per clock, a programmable number of times, with an optional idle gap between repetitions. It feeds detector benches and on-chip loopback self-test, and its output connects directly to the detector's data/valid inputs.

Parameters:
NUM_BITS, 5, pattern width in bits (>=2)
PATTERN, 5'b10110, default pattern, used when use_default=1
REP_W, 4, width of repetition-count input
GAP_W, 3, width of inter-repetition gap input

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  reset; synchronous, active-high
start  input  1  request a transmission; sampled only in IDLE
use_default  input  1  1: send PATTERN; 0: send pattern_in (sampled with start)
pattern_in  input  NUM_BITS  runtime pattern (sampled with start)
reps  input  REP_W  number of pattern repetitions (sampled with start)
gap  input  GAP_W  idle cycles between repetitions (sampled with start)
fill  input  1  data value driven while valid=0
abort  input  1  cancel an in-progress transmission
data  output  1  serial bit, MSB of pattern first
valid  output  1  data carries a pattern bit
busy  output  1  transmission in progress
done  output  1  one-cycle pulse at normal completion
sent_cnt  output  REP_W  completed repetitions of the current or last job

Behaviour:
- All outputs registered. Reset (rst=1 at a clk edge): state IDLE, data=0, valid=0, busy=0, done=0, sent_cnt=0, all latches cleared. Reset has priority over abort and start and takes effect mid-transmission; no done is issued.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE: data=fill, valid=0. start=1 at edge T: latch pattern (PATTERN or pattern_in), reps, gap; clear sent_cnt; busy=1 from T+1.
  - reps!=0: go to SEND; first bit (pattern[NUM_BITS-1]) appears with valid=1 in cycle T+1 (latency 1).
  - reps==0: go to FIN; no valid bits are sent; done pulses in cycle T+1.
- SEND: one bit per cycle, index NUM_BITS-1 down to 0, valid=1. After bit 0: sent_cnt increments.
  - Repetitions remaining and gap==0: next cycle carries the next repetition's MSB; valid stays continuously high.
  - Repetitions remaining and gap>0: go to GAP.
  - Last repetition: go to FIN.
- GAP: exactly gap cycles with valid=0 and data=fill, then SEND at the MSB.
- FIN: one cycle, valid=0, done=1, busy=1. Then IDLE with busy=0 and done=0. sent_cnt holds until the next start.
- start while busy=1 is ignored, including in the FIN cycle. pattern_in, reps, gap and use_default changes mid-job have no effect.
- abort=1 at an edge while busy: go to IDLE next cycle with valid=0, busy=0 and no done. sent_cnt keeps the count of complete repetitions. A partial repetition is not counted. abort in IDLE is ignored.
- Total job length for reps=R>0: R*NUM_BITS + (R-1)*gap cycles from the first valid bit to the last valid bit. done follows the last bit by 1 cycle.

Optional Feature:
Macro PATT_GEN_LFSR_EN.
- Defined: adds an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 on rst, advances every cycle). During GAP, data is the LFSR bit 0 with valid=1, which injects noise bits between repetitions to stress detector overlap and reset-of-match logic. The fill input is still used in IDLE and FIN. The job length formula is unchanged.
- Undefined: no LFSR logic. GAP behaves as specified above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> valid=0, busy=0, done=0, sent_cnt=0 throughout and 1 cycle after release.
- use_default=1, reps=3, gap=0, start at T -> valid=1 in T+1..T+15, data=101101011010110, done=1 only in T+16, sent_cnt=3, busy=0 in T+17.
- pattern_in=5'b11001, use_default=0, reps=2, gap=2, fill=1 -> cycles T+1..T+5 valid=1 with 11001; T+6..T+7 valid=0 with data=1; T+8..T+12 valid=1 with 11001; done in T+13. With PATT_GEN_LFSR_EN, T+6..T+7 have valid=1 and data=LFSR bits.
- reps=0, start -> no valid cycle, done in T+1, sent_cnt=0.
- reps=4, gap=0; abort during the 2nd bit of the 3rd repetition -> valid=0 and busy=0 the next cycle, done never asserted, sent_cnt=2. A second start pulsed mid-job is ignored.
- rst=1 mid-SEND -> all outputs at reset values the next cycle. A subsequent start produces a full, correct job.
